serial_sum_collector: RTL and testbench
=======================================

// Module: serial_sum_collector
// PURPOSE
//  Downstream stage of the bit-serial summator: deserialises its 1-bit, LSB-first sum stream into a
//  parallel word of reglength+1 bits (final carry as MSB). Presents the word on a valid/ready
//  handshake to the consumer. Tracks bit position with a counter and a 3-state FSM.
// PARAMETERS
//  reglength  3  operand width of the upstream summator; result width RESW = reglength+1
// PORTS
//  clk        in   1          system clock, all state updates on posedge
//  reset      in   1          asynchronous, active-low reset (0 = reset asserted)
//  start      in   1          1-cycle pulse aligned with the summator operand load; begins a new word
//  sum_in     in   1          serial sum bit from summator, LSB first, one bit per clk
//  out_ready  in   1          consumer accepts result when out_valid & out_ready at posedge
//  result     out  RESW       collected sum, bit0 = first serial bit received
//  out_valid  out  1          result complete and stable
//  busy       out  1          high while in COLLECT
//  overrun    out  1          sticky: start arrived in DONE without out_ready; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, result=0, cnt=0, out_valid=0, busy=0, overrun=0.
//  States: IDLE, COLLECT, DONE (encoded 2'b00/01/10; 2'b11 recovers to IDLE next clk).
//  IDLE:    start=1 -> COLLECT, shreg<=0, cnt<=0. Else hold.
//  COLLECT: each posedge shreg <= {sum_in, shreg[RESW-1:1]}, cnt<=cnt+1.
//           First captured bit = sum_in at the first posedge AFTER the one that sampled start.
//           When cnt==RESW-1 at capture -> DONE; result<=final shreg value.
//           start=1 in COLLECT: abort, restart (shreg<=0, cnt<=0, no bit captured that cycle).
//  DONE:    out_valid=1, result held stable until handshake.
//           out_ready=1 & start=0 -> IDLE, out_valid<=0.
//           out_ready=1 & start=1 -> handshake completes AND new word begins (-> COLLECT, no idle gap).
//           out_ready=0 & start=1 -> start dropped, overrun<=1, stay DONE.
//  Latency: start at edge N -> out_valid high after edge N+RESW (RESW sum bits captured).
//  result updates only on entry to DONE; holds last value in IDLE/COLLECT (no glitching).
//  cnt width = $clog2(RESW+1); cnt never exceeds RESW-1; no wrap in legal operation.
//  busy = (state==COLLECT); out_valid = (state==DONE); both registered-state decodes.
//  Reset asserted mid-COLLECT or mid-DONE: immediate return to reset values; partial word lost.
//  sum_in ignored outside COLLECT.
// STRUCTURE
//  Shared package summator_pkg: state localparams (ST_IDLE/ST_COLLECT/ST_DONE), RESW formula
//  reused by summator testbenches.
//  One natural sub-module: sum_shift_reg (RESW-bit right shift register with sync clear and
//  shift enable, async active-low reset). FSM, counter and handshake stay in this module.
// TESTING (reglength=3, RESW=4)
//  1 5+6: start, sum_in 1,1,0,1 on next 4 edges -> out_valid after 4th edge, result=4'b1011,
//    busy high 4 cycles
//  2 7+7: sum_in 0,1,1,1 -> result=4'b1110; out_ready held 0 for 3 cycles -> result/out_valid
//    stable; out_ready=1 -> IDLE
//  3 Back-to-back: in DONE drive start=1 with out_ready=1 -> word accepted, busy=1 next cycle,
//    second word 0,0,0,0 -> result=0
//  4 Abort: start, 2 bits 1,1, start again, then 1,0,0,0 -> result=4'b0001 (first bits discarded)
//  5 Overrun: in DONE start=1, out_ready=0 -> overrun=1, result unchanged; stays 1 after later
//    handshake
//  6 Reset mid-COLLECT after 2 bits: reset=0 -> all outputs 0 asynchronously (before next edge);
//    release, new word 1,0,1,0 -> result=4'b0101

Source files
------------

// File: rtl/summator_pkg.sv
// Shared definitions for the bit-serial summator and its collector: FSM state encoding and result width.
package summator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    // Result carries the final carry above the operand bits.
    function automatic int resw_f(input int reglength);
        return reglength + 1;
    endfunction

endpackage

// File: rtl/sum_shift_reg.sv
// Right shift register for LSB-first serial data: new bit enters at the MSB, sync clear wins over shift.
// State is visible on q_o the cycle after the edge; no flow control of its own.
module sum_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         shift_i,
    input  logic         din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (shift_i) begin
            q_d = {din_i, q_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_sum_collector.sv
// Deserialises the summator's LSB-first sum stream into a RESW-bit word; out_valid rises RESW edges after start.
// Word is held in DONE until out_ready; a start seen in DONE without out_ready is dropped and flagged as overrun.
module serial_sum_collector
    import summator_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sum_in,
    input  logic             out_ready,
    output logic [reglength:0] result,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int RESW  = resw_f(reglength);
    localparam int CNT_W = $clog2(RESW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESW - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RESW-1:0]   result_q, result_d;
    logic              overrun_q, overrun_d;
    logic [RESW-1:0]   sh_q;
    logic [RESW-1:0]   sh_next;
    logic              sh_clr;
    logic              sh_shift;

    sum_shift_reg #(.W(RESW)) u_shreg (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (sh_clr),
        .shift_i (sh_shift),
        .din_i   (sum_in),
        .q_o     (sh_q)
    );

    // Value the shift register will hold after this edge's capture; latched into result on the last bit.
    assign sh_next = {sum_in, sh_q[RESW-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        overrun_d = overrun_q;
        sh_clr    = 1'b0;
        sh_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    sh_clr  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (start) begin
                    sh_clr = 1'b1;
                    cnt_d  = '0;
                end else begin
                    sh_shift = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        result_d = sh_next;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = ST_COLLECT;
                        sh_clr  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            overrun_q <= overrun_d;
        end
    end

    assign result    = result_q;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_COLLECT);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector (RESW=4): expected words queued at start, checked on completion.
module tb_serial_sum_collector;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sum_in;
    logic       out_ready;
    logic [3:0] result;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    int         vectors;
    int         miscompares;
    logic [3:0] exp_q[$];
    logic [3:0] exp_w;

    serial_sum_collector #(.reglength(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sum_in    (sum_in),
        .out_ready (out_ready),
        .result    (result),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1ns after the following rising edge.
    task automatic cyc(input logic s, input logic d, input logic r);
        @(negedge clk);
        start     = s;
        sum_in    = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp_w = exp_q.pop_front();
            chk({tag, "_result"}, 32'(result), 32'(exp_w));
        end
    endtask

    // Start pulse (optionally with out_ready, for back-to-back from DONE) followed by 4 serial bits.
    task automatic run_word(input string tag, input logic [3:0] w, input logic rdy_at_start);
        exp_q.push_back(w);
        cyc(1'b1, 1'b0, rdy_at_start);
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        chk({tag, "_valid_start"}, 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, w[i], 1'b0);
            if (i < 3) begin
                chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
                chk({tag, "_valid_mid"}, 32'(out_valid), 32'd0);
            end else begin
                chk({tag, "_valid_done"}, 32'(out_valid), 32'd1);
                chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            end
        end
        check_word(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        sum_in      = 1'b0;
        out_ready   = 1'b0;
        #3;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: 5+6 = 11
        run_word("t1", 4'b1011, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t1_valid_after_hs", 32'(out_valid), 32'd0);

        // 2: 7+7 = 14, consumer stalls 3 cycles
        run_word("t2", 4'b1110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("t2_stall_valid", 32'(out_valid), 32'd1);
            chk("t2_stall_result", 32'(result), 32'hE);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("t2_idle_valid", 32'(out_valid), 32'd0);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t2_idle_hold", 32'(result), 32'hE);

        // 3: back-to-back, second word begins on the handshake cycle
        run_word("t3a", 4'b0110, 1'b0);
        run_word("t3b", 4'b0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // 4: abort after two bits, restart
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_result_hold", 32'(result), 32'd0);
        run_word("t4", 4'b0001, 1'b0);

        // 5: overrun in DONE
        cyc(1'b1, 1'b0, 1'b0);
        chk("t5_overrun", 32'(overrun), 32'd1);
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_result", 32'(result), 32'h1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t5_overrun_sticky", 32'(overrun), 32'd1);
        chk("t5_idle_valid", 32'(out_valid), 32'd0);

        // 6: asynchronous reset mid-COLLECT
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_result", 32'(result), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_word("t6", 4'b0101, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
